resp_noc_arbiter: RTL

- Shares the single responder-NoC write port between N_PORT responder instances (one per ant/requester id).
- Each port has a one-entry holding slot. A round-robin scheduler drains the slots into the NoC under the full/almost_full backpressure rule.
- Sits between the responder array and the responder NoC injection port. Packets pass through unmodified except the valid bit, which is forced to 1.

---
 rtl/resp_noc_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/resp_noc_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/resp_noc_pkg.sv
// Shared widths, packet field offsets and packet layout for the responder NoC arbiter.
// The packet is {data, reg_id, dest, valid}; bit 0 marks a packet worth sending.
package resp_noc_pkg;

  localparam int DATA_W = 16;
  localparam int RESP_W = DATA_W + 6 + 3;
  localparam int N_PORT = 4;
  localparam int PTR_W  = $clog2(N_PORT);

  localparam int VALID_BIT = 0;
  localparam int DEST_LSB  = 1;
  localparam int DEST_MSB  = 2;
  localparam int REGID_LSB = 3;
  localparam int REGID_MSB = 8;
  localparam int DATA_LSB  = 9;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [5:0]        reg_id;
    logic [1:0]        dest;
    logic              valid;
  } resp_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester found scanning upward from ptr with wrap.
// Grants are suppressed when enable is low; winner/found still report the candidate.
import resp_noc_pkg::*;

module rr_arbiter (
  input  logic [N_PORT-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              enable,
  output logic [N_PORT-1:0] grant,
  output logic [PTR_W-1:0]  winner,
  output logic              found
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    // N_PORT is a power of two, so the PTR_W-bit add wraps for free.
    for (int k = 0; k < N_PORT; k++) begin
      cand = ptr + PTR_W'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    if (found && enable) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/resp_noc_arbiter.sv
// Shares the responder NoC write port among N_PORT one-entry slots, round-robin, with full/almost_full backpressure.
// Define RESP_ARB_STATS_EN to add per-port saturating grant counters on grant_cnt.
import resp_noc_pkg::*;

module resp_noc_arbiter (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_PORT-1:0]        req_valid,
  input  logic [N_PORT*RESP_W-1:0] req_data,
  output logic [N_PORT-1:0]        req_ready,
  input  logic                     full,
  input  logic                     almost_full,
  output logic [RESP_W-1:0]        dataOut,
  output logic                     write,
  output logic [PTR_W-1:0]         grant_id
`ifdef RESP_ARB_STATS_EN
  ,
  output logic [N_PORT*16-1:0]     grant_cnt
`endif
);

  // Handshake: slot i loads on req_valid[i] & req_ready[i]; req_ready never depends on req_valid.
  resp_pkt_t         slot_q [N_PORT];
  logic [N_PORT-1:0] slot_valid;
  logic [PTR_W-1:0]  rr_ptr;
  logic              can_write;
  logic [N_PORT-1:0] grant_now;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  resp_pkt_t         out_pkt;

  // A write registered this cycle consumes one buffer entry before the next can land.
  assign can_write = write ? ~almost_full : ~full;

  rr_arbiter u_rr (
    .req    (slot_valid),
    .ptr    (rr_ptr),
    .enable (can_write),
    .grant  (grant_now),
    .winner (win_idx),
    .found  (win_found)
  );

  assign req_ready = ~slot_valid | grant_now;

  always_comb begin
    out_pkt       = slot_q[win_idx];
    out_pkt.valid = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataOut    <= '0;
      write      <= 1'b0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      slot_valid <= '0;
      for (int i = 0; i < N_PORT; i++) slot_q[i] <= '0;
    end else begin
      write <= |grant_now;
      if (|grant_now) begin
        dataOut  <= out_pkt;
        grant_id <= win_idx;
        rr_ptr   <= win_idx + PTR_W'(1);
      end
      for (int i = 0; i < N_PORT; i++) begin
        if (grant_now[i]) slot_valid[i] <= 1'b0;
        // Refill after drain: this later assignment wins, so the new packet is kept.
        if (req_valid[i] && req_ready[i]) begin
          slot_q[i]     <= req_data[i*RESP_W +: RESP_W];
          slot_valid[i] <= req_data[i*RESP_W + VALID_BIT];
        end
      end
    end
  end

`ifdef RESP_ARB_STATS_EN
  logic [15:0] cnt_q [N_PORT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PORT; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORT; i++)
        if (grant_now[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_PORT; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule
